// File: rtl/spi_flash_writer.sv
// spi_flash_writer: SPI NOR programmer (WREN, page program / 4 KiB sector erase, WIP polling).
// Latency: a rejected program reports done+error one cycle after start; other commands take SPI-bound time.
// Backpressure: every SPI byte and every source fetch waits for its toggle ack; starts are ignored unless idle.
// Ports: start_program/start_erase with flash_addr/src_addr/amount in; busy/done/error status out;
//   cs_n/spi_req/spi_d out and spi_ack/spi_q in for the byte SPI master; req/a out and ack/q in for the byte source.
`timescale 1ns/1ps
module spi_flash_writer #(
  parameter int          a_bits        = 14,
  parameter int          cs_gap_cycles = 10,
  parameter logic [23:0] poll_limit    = 24'd4000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_program,
  input  logic              start_erase,
  input  logic [23:0]       flash_addr,
  input  logic [a_bits-1:0] src_addr,
  input  logic [8:0]        amount,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cs_n,
  output logic              spi_req,
  input  logic              spi_ack,
  output logic [7:0]        spi_d,
  input  logic [7:0]        spi_q,
  output logic              req,
  input  logic              ack,
  output logic [a_bits-1:0] a,
  input  logic [7:0]        q
);

  localparam int GW = (cs_gap_cycles > 1) ? $clog2(cs_gap_cycles) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WREN, S_GAP, S_CMD, S_ADDR, S_DATA, S_PCMD, S_PRD} state_t;
  // What the gap leads into once cs_n has been high long enough.
  typedef enum logic [1:0] {AF_CMD, AF_POLL, AF_STAT} after_t;

  state_t state_q, state_d;
  after_t after_q, after_d;
  logic cs_n_q, cs_n_d, spi_req_q, spi_req_d, spi_iss_q, spi_iss_d;
  logic req_q, req_d, fetch_q, fetch_d, have_q, have_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d, prog_q, prog_d, wip_q, wip_d;
  logic [7:0]        spi_d_q, spi_d_d, buf_q, buf_d;
  logic [a_bits-1:0] a_q, a_d, src_q, src_d;
  logic [23:0]       faddr_q, faddr_d, poll_q, poll_d;
  logic [8:0]        amount_q, amount_d, cnt_q, cnt_d, fidx_q, fidx_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic       spi_fin, pg_ok, tx_en;
  logic [7:0] tx_byte;
  logic       unused_bits;

  assign unused_bits = ^spi_q[7:1];
  // The issued flag separates "transfer finished" from "nothing launched yet".
  assign spi_fin = spi_iss_q & ~(spi_req_q ^ spi_ack);
  // A program must be non-empty and stay inside one 256-byte page.
  assign pg_ok = (amount != 9'd0) && (({2'b00, flash_addr[7:0]} + {1'b0, amount}) <= 10'd256);

  always_comb begin
    state_d = state_q;  after_d = after_q;  cs_n_d = cs_n_q;
    spi_req_d = spi_req_q;  spi_iss_d = spi_iss_q;  spi_d_d = spi_d_q;
    req_d = req_q;  fetch_d = fetch_q;  have_d = have_q;  buf_d = buf_q;  a_d = a_q;
    busy_d = busy_q;  done_d = 1'b0;  error_d = error_q;  prog_d = prog_q;  wip_d = wip_q;
    src_d = src_q;  faddr_d = faddr_q;  poll_d = poll_q;  amount_d = amount_q;
    cnt_d = cnt_q;  fidx_d = fidx_q;  gap_d = gap_q;
    tx_en = 1'b0;  tx_byte = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start_erase || start_program) begin
          faddr_d = flash_addr;  src_d = src_addr;  amount_d = amount;
          poll_d = '0;  cnt_d = '0;  fidx_d = '0;  error_d = 1'b0;
          if (start_erase) begin          // erase wins a simultaneous start
            prog_d = 1'b0;  busy_d = 1'b1;  state_d = S_WREN;
          end else if (pg_ok) begin
            prog_d = 1'b1;  busy_d = 1'b1;  state_d = S_WREN;
          end else begin
            done_d = 1'b1;  error_d = 1'b1;
          end
        end
      end
      S_WREN: begin
        tx_en = 1'b1;  tx_byte = 8'h06;
        if (spi_fin) begin cs_n_d = 1'b1;  after_d = AF_CMD;  gap_d = '0;  state_d = S_GAP; end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(cs_gap_cycles - 1)) begin
          gap_d = '0;
          // cs_n drops on the exit edge so it is high for exactly cs_gap_cycles.
          if (after_q == AF_CMD) begin
            cs_n_d = 1'b0;  state_d = S_CMD;
          end else if (after_q == AF_POLL || (wip_q && poll_q != poll_limit)) begin
            cs_n_d = 1'b0;  state_d = S_PCMD;
          end else begin
            done_d = 1'b1;  busy_d = 1'b0;  error_d = wip_q;  state_d = S_IDLE;
          end
        end
      end
      S_CMD: begin
        tx_en = 1'b1;  tx_byte = prog_q ? 8'h02 : 8'h20;
        if (spi_fin) begin cnt_d = '0;  state_d = S_ADDR; end
      end
      S_ADDR: begin
        tx_en = 1'b1;
        case (cnt_q[1:0])
          2'd0:    tx_byte = faddr_q[23:16];
          2'd1:    tx_byte = faddr_q[15:8];
          default: tx_byte = faddr_q[7:0];
        endcase
        if (spi_fin) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'd2) begin
            cnt_d = '0;
            if (prog_q) state_d = S_DATA;
            else begin cs_n_d = 1'b1;  after_d = AF_POLL;  state_d = S_GAP; end
          end
        end
      end
      S_DATA: begin
        // One-byte buffer: the next fetch runs while the previous byte shifts out.
        if (fetch_q && (req_q == ack)) begin
          buf_d = q;  have_d = 1'b1;  fetch_d = 1'b0;
        end else if (!fetch_q && !have_q && (fidx_q < amount_q)) begin
          a_d = src_q + a_bits'(fidx_q);
          req_d = ~req_q;  fetch_d = 1'b1;  fidx_d = fidx_q + 9'd1;
        end
        tx_en = have_q;  tx_byte = buf_q;
        if (have_q && !spi_iss_q) have_d = 1'b0;
        if (spi_fin) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == amount_q - 9'd1) begin cs_n_d = 1'b1;  after_d = AF_POLL;  state_d = S_GAP; end
        end
      end
      S_PCMD: begin
        tx_en = 1'b1;  tx_byte = 8'h05;
        if (spi_fin) state_d = S_PRD;
      end
      S_PRD: begin
        tx_en = 1'b1;  tx_byte = 8'h00;
        if (spi_fin) begin
          wip_d = spi_q[0];  poll_d = poll_q + 24'd1;
          cs_n_d = 1'b1;  after_d = AF_STAT;  state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (spi_fin) begin
      spi_iss_d = 1'b0;
    end else if (tx_en && !spi_iss_q) begin
      spi_d_d = tx_byte;  spi_req_d = ~spi_req_q;  spi_iss_d = 1'b1;  cs_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  after_q <= AF_CMD;  cs_n_q <= 1'b1;
      spi_req_q <= 1'b0;  spi_iss_q <= 1'b0;  spi_d_q <= 8'h00;
      req_q <= 1'b0;  fetch_q <= 1'b0;  have_q <= 1'b0;  buf_q <= 8'h00;  a_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;  prog_q <= 1'b0;  wip_q <= 1'b0;
      src_q <= '0;  faddr_q <= '0;  poll_q <= '0;  amount_q <= '0;
      cnt_q <= '0;  fidx_q <= '0;  gap_q <= '0;
    end else begin
      state_q <= state_d;  after_q <= after_d;  cs_n_q <= cs_n_d;
      spi_req_q <= spi_req_d;  spi_iss_q <= spi_iss_d;  spi_d_q <= spi_d_d;
      req_q <= req_d;  fetch_q <= fetch_d;  have_q <= have_d;  buf_q <= buf_d;  a_q <= a_d;
      busy_q <= busy_d;  done_q <= done_d;  error_q <= error_d;  prog_q <= prog_d;  wip_q <= wip_d;
      src_q <= src_d;  faddr_q <= faddr_d;  poll_q <= poll_d;  amount_q <= amount_d;
      cnt_q <= cnt_d;  fidx_q <= fidx_d;  gap_q <= gap_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign cs_n    = cs_n_q;
  assign spi_req = spi_req_q;
  assign spi_d   = spi_d_q;
  assign req     = req_q;
  assign a       = a_q;

endmodule
